// File: rtl/sram_model_pipe.sv
// sram_model_pipe: behavioural external SRAM with byte lanes, registered read latency, init sweep and error flag
//   clk, rst       clock; asynchronous active-high reset
//   sram_addr      word address (wraps modulo 2**ADDR_W)
//   sram_io        shared data bus, driven per lane from the output stage when ce_b/oe_b/lane mask allow
//   sram_ce_b      chip enable, sram_we_b write enable, sram_oe_b output enable (all active low)
//   sram_be_b      per-lane enable, active low
//   init_done      model accepts accesses
//   rd_valid       one-cycle pulse when read data reaches the output stage
//   err_flag       sticky: access during init sweep, or ce/we/oe all low at an edge
module sram_model_pipe #(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 16,
  parameter int LANE_W = 8,
  parameter int READ_LAT = 1,
  parameter int INIT_MODE = 0,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [ADDR_W-1:0]          sram_addr,
  inout  wire  [DATA_W-1:0]          sram_io,
  input  logic                       sram_ce_b,
  input  logic                       sram_we_b,
  input  logic                       sram_oe_b,
  input  logic [DATA_W/LANE_W-1:0]   sram_be_b,
  output logic                       init_done,
  output logic                       rd_valid,
  output logic                       err_flag
);
  localparam int LANES = DATA_W / LANE_W;
  localparam int DEPTH = 2 ** ADDR_W;
  typedef enum logic {INIT, READY} state_t;
  state_t state, state_nxt;
  logic [ADDR_W-1:0] cnt;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] out_d;
  logic [LANES-1:0] out_m;
  logic acc, clash, wr_en, rd_iss;
  assign acc = ~sram_ce_b;
  assign clash = acc & ~sram_we_b & ~sram_oe_b;
  // a contended write (oe_b also low) is dropped
  assign wr_en = init_done & acc & ~sram_we_b & sram_oe_b;
  assign rd_iss = init_done & acc & sram_we_b;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= (INIT_MODE == 1) ? INIT : READY;
    else state <= state_nxt;
  always_comb state_nxt = (state == INIT && cnt == '1) ? READY : state;
  always_comb init_done = state == READY;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else if (state == INIT) cnt <= cnt + 1'b1;
  always_ff @(posedge clk or posedge rst)
    if (rst) err_flag <= 1'b0;
    else if ((state == INIT && acc) || clash) err_flag <= 1'b1;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      if (INIT_MODE == 0) for (int i = 0; i < DEPTH; i++) mem[i] <= INIT_VAL;
    end else if (state == INIT) mem[cnt] <= INIT_VAL;
    else if (wr_en)
      for (int i = 0; i < LANES; i++)
        if (!sram_be_b[i]) mem[sram_addr][i*LANE_W +: LANE_W] <= sram_io[i*LANE_W +: LANE_W];
  generate
    if (READ_LAT == 0) begin : g_comb
      always_comb begin
        out_d = mem[sram_addr];
        out_m = ~sram_be_b;
        rd_valid = rd_iss;
      end
    end else begin : g_pipe
      // the last stage doubles as the output stage: it only loads on a valid read and holds otherwise
      logic [READ_LAT-1:0] pv;
      logic [DATA_W-1:0] pd [READ_LAT];
      logic [LANES-1:0] pm [READ_LAT];
      always_ff @(posedge clk or posedge rst)
        if (rst) begin
          pv <= '0;
          for (int i = 0; i < READ_LAT; i++) begin
            pd[i] <= '0;
            pm[i] <= '0;
          end
        end else begin
          pv <= READ_LAT'({pv, rd_iss});
          if (rd_iss) begin
            pd[0] <= mem[sram_addr];
            pm[0] <= ~sram_be_b;
          end
          for (int i = 1; i < READ_LAT; i++)
            if (pv[i-1]) begin
              pd[i] <= pd[i-1];
              pm[i] <= pm[i-1];
            end
        end
      assign out_d = pd[READ_LAT-1];
      assign out_m = pm[READ_LAT-1];
      assign rd_valid = pv[READ_LAT-1];
    end
  endgenerate
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    assign sram_io[i*LANE_W +: LANE_W] = (~sram_oe_b & ~sram_ce_b & out_m[i]) ? out_d[i*LANE_W +: LANE_W] : {LANE_W{1'bz}};
  end
endmodule

// File: doc/sram_model_pipe.md
Name: sram_model_pipe

Overview:
- Parametrised behavioural model of an asynchronous-style external SRAM for testbenches of the memory interface and frame buffer path.
- Generalises data width, address width and byte-lane count.
- Adds a configurable registered read latency, an optional post-reset sequential initialisation sweep, a read-valid strobe and sticky protocol-error detection.
- Drives the shared bidirectional data bus exactly as the physical part would at the pins.

Parameters:
- ADDR_W, 20, address width; depth = 2**ADDR_W words.
- DATA_W, 16, data word width; must be a multiple of LANE_W.
- LANE_W, 8, bits per byte lane; LANES = DATA_W/LANE_W.
- READ_LAT, 1, read latency in clk cycles, legal range 0..4.
- INIT_MODE, 0, reset initialisation mode: 0 = instant clear during reset; 1 = sequential sweep after reset.
- INIT_VAL, 0, word value written to every location on initialisation.

Ports:
- clk  in  1  clock.
- rst  in  1  reset.
- sram_addr  in  ADDR_W  word address.
- sram_io  inout  DATA_W  shared data bus.
- sram_ce_b  in  1  chip enable, active low.
- sram_we_b  in  1  write enable, active low.
- sram_oe_b  in  1  output enable, active low.
- sram_be_b  in  LANES  per-lane enable, active low; bit i covers sram_io[i*LANE_W +: LANE_W].
- init_done  out  1  high when the model accepts accesses.
- rd_valid  out  1  one-cycle pulse when read data reaches the output stage.
- err_flag  out  1  sticky protocol-error flag.

Behaviour:
- Reset: rst is asynchronous and active-high; clock is clk.
- Output reset values: rd_valid=0, err_flag=0, output stage data=0, output stage lane mask=0 (bus z).
- Reset with INIT_MODE=0: all words set to INIT_VAL, init_done=1.
- Reset with INIT_MODE=1: init_done=0 and sweep counter=0.
- Init sweep (INIT_MODE=1):
  - States: INIT, READY.
  - INIT writes INIT_VAL to mem[cnt] each cycle, then cnt++.
  - After address 2**ADDR_W-1 is written, the next edge enters READY and sets init_done=1. The sweep lasts 2**ADDR_W cycles.
  - rst asserted mid-sweep restarts it from address 0.
  - Any access (ce_b=0) during INIT is ignored and sets err_flag.
- Write, sampled on posedge clk when init_done & ~ce_b & ~we_b:
  - For each lane i with ~be_b[i], that lane of mem[addr] takes sram_io.
  - Disabled lanes are left unchanged.
  - A write has priority over a read in the same cycle.
- Read issue, on posedge when init_done & ~ce_b & we_b:
  - Capture mem[addr] and the ~be_b lane mask into pipeline stage 1.
  - Data is captured at issue, so a write to the same address in a later cycle does not alter a read already in flight.
- Pipeline:
  - READ_LAT stages, each holding a valid bit, data and lane mask.
  - When a read reaches the last stage, the output stage loads it and rd_valid pulses for exactly one cycle.
  - The output stage holds its data until the next completed read.
- READ_LAT=0: fully combinational.
  - Output data = mem[sram_addr] masked by the current be_b.
  - rd_valid = init_done & ~ce_b & we_b, combinational.
- Bus drive:
  - Lane i of sram_io = output-stage lane i when ~oe_b & ~ce_b & lane-mask[i]; otherwise z.
  - oe_b acts combinationally, with no latency.
- Contention: ~ce_b & ~we_b & ~oe_b at a clock edge sets err_flag and suppresses the write.
- Back-to-back reads: one read per cycle is accepted; throughput is 1 word/cycle.
- Address wrap: addresses are taken modulo 2**ADDR_W, so no out-of-range case exists.
- err_flag clears only on rst.

Test Plan:
- INIT_MODE=1, ADDR_W=4, INIT_VAL=16'hA5A5: release rst -> init_done rises after 16 cycles; reading addr 7 then returns 16'hA5A5.
- READ_LAT=2: write 16'h1234 to addr 3 (be_b=2'b00), then issue a read of addr 3 with oe_b=0 -> rd_valid pulses 2 cycles after issue; sram_io=16'h1234.
- Byte lanes: write 16'hBEEF to addr 5 with be_b=2'b01 over prior 16'h0000 -> readback with be_b=2'b00 gives 16'hBE00; read with be_b=2'b10 drives only the low lane (8'h00) and leaves the high lane z.
- Read/write ordering, READ_LAT=3: read addr 9 (holds 16'h0001), then write 16'h0002 to addr 9 on the next cycle -> the first read returns 16'h0001; a subsequent read returns 16'h0002.
- Contention: ce_b=0, we_b=0, oe_b=0 at an edge -> err_flag=1 and mem unchanged; err_flag stays 1 until rst.
- Reset mid-sweep: assert rst at sweep address 6 -> on release init_done=0 and the sweep restarts at address 0; access during INIT sets err_flag.
